cache_ctrl: RTL and testbench
=============================

// Module: cache_ctrl
// PURPOSE
//  Sequencer between the CPU load port and the direct-mapped cache array (256 blocks x 16 words x 32b).
//  Accepts one word-address read at a time, probes the array, and returns data on a hit.
//  On a miss, fetches the 512b block from main memory, drives a fill cycle into the array and returns the word.
//  Sits between the CPU and the cache array / RAM; also keeps hit and miss statistics.
// PARAMETERS
//  ADDR_W   32   word-address width; [3:0] = word offset, [11:4] = index, [31:12] = tag
//  WORD_W   32   data word width
//  BLOCK_W  512  block width (16 words); mem_data / cache_din width
//  CNT_W    32   width of the hit/miss statistics counters
// PORTS
//  clk         in   1        rising-edge clock
//  rst         in   1        asynchronous, active-high reset
//  cpu_req     in   1        read request; accepted when cpu_req && cpu_ready
//  cpu_addr    in   ADDR_W   word address, sampled on acceptance
//  cpu_ready   out  1        high only in IDLE
//  cpu_valid   out  1        one-cycle pulse: cpu_rdata valid
//  cpu_rdata   out  WORD_W   returned word; held until next cpu_valid
//  cache_addr  out  ADDR_W   address to array (latched request address)
//  cache_read  out  1        1 = lookup, 0 = fill; never X
//  cache_din   out  BLOCK_W  fill block to array (fill buffer)
//  cache_hit   in   1        array hit flag, registered by array
//  cache_dout  in   WORD_W   array word out, registered by array
//  mem_req     out  1        block fetch request, held until mem_ready
//  mem_addr    out  ADDR_W   block-aligned fetch address {addr[31:4],4'b0}
//  mem_ready   in   1        mem_data valid this cycle; ignored unless mem_req
//  mem_data    in   BLOCK_W  fetched block
//  hit_cnt     out  CNT_W    lookups that hit, saturating
//  miss_cnt    out  CNT_W    lookups that missed, saturating
// BEHAVIOUR
//  Reset: state=IDLE; cpu_ready=1; cpu_valid=0, mem_req=0, cpu_rdata=0, cache_read=1,
//   addr_q=0, fill_buf=0, hit_cnt=0, miss_cnt=0. The array has no reset; contents survive rst.
//  States: IDLE -> LOOKUP -> COMPARE -> {RESP | MEM_WAIT -> FILL -> FILL_RD -> RESP} -> IDLE.
//   IDLE: on cpu_req, latch addr_q <= cpu_addr and go to LOOKUP.
//   LOOKUP: cache_read=1; the array registers hit/dout at the end of this cycle.
//   COMPARE: if cache_hit, rdata <= cache_dout, hit_cnt++, go to RESP;
//    else miss_cnt++, go to MEM_WAIT.
//   MEM_WAIT: mem_req=1. On mem_ready, fill_buf <= mem_data and go to FILL.
//   FILL: cache_read=0 for exactly one cycle; the array writes the block and registers the word.
//   FILL_RD: rdata <= cache_dout, go to RESP.
//   RESP: cpu_valid=1 for one cycle, then IDLE.
//  cache_read=0 only in FILL. cache_addr = addr_q in all states.
//  Latency, accept edge to cpu_valid: hit = 3 cycles; miss = 6 + N cycles, N = mem_ready wait cycles.
//  Back-to-back: the next request is accepted in the IDLE cycle after RESP (throughput 1 per 4 on hits).
//  The array's hit flag in FILL_RD is ignored; the fill always completes as a hit.
//  Counters saturate at all-ones and never wrap.
//  rst mid-operation (e.g. in MEM_WAIT): mem_req drops immediately; no cpu_valid; no partial fill.
//  cpu_req while busy is ignored (cpu_ready=0); the requester holds it.
// STRUCTURE
//  Shared header cache_defs.vh holds BLOCKS, WORDS, SIZE, BLOCK_SIZE, TAG and the state encodings,
//   so the array and this controller agree.
//  One sub-module: cache_stat_cnt (CNT_W saturating incrementer, async reset), instantiated twice.
//  FSM, addr_q, fill_buf and rdata register live in cache_ctrl.
// TESTING (bench includes behavioural array + RAM with programmable mem_ready delay)
//  1. Cold read 0x0000_1234, mem delay 2 -> mem_addr=0x0000_1230; cpu_valid at cycle 8;
//     rdata = word 4 of block; miss_cnt=1.
//  2. Repeat read 0x0000_1235 -> cpu_valid 3 cycles after accept; word 5; hit_cnt=1; no mem_req.
//  3. Conflict: 0x0000_1234 then 0x0010_1234 (same index, new tag) -> second misses;
//     re-read of 0x0000_1234 misses again; miss_cnt=3.
//  4. rst pulsed mid MEM_WAIT -> mem_req=0 and state IDLE same cycle; no cpu_valid;
//     counters=0; a later hit on a block filled before rst still hits.
//  5. cpu_req held high continuously, 4 hits -> accepts spaced exactly 4 cycles; cpu_ready low while busy.
//  6. Preload hit_cnt near all-ones, force 3 hits -> hit_cnt sticks at 0xFFFF_FFFF.

Source files
------------

// File: rtl/cache_ctrl_pkg.sv
// cache_ctrl_pkg: geometry and FSM encoding shared by the cache controller and the cache array.
package cache_ctrl_pkg;
    localparam int BLOCKS     = 256;
    localparam int WORDS      = 16;
    localparam int SIZE       = BLOCKS * WORDS;
    localparam int BLOCK_SIZE = WORDS * 32;
    localparam int OFF_W      = $clog2(WORDS);
    localparam int IDX_W      = $clog2(BLOCKS);
    localparam int TAG        = 32 - OFF_W - IDX_W;
    typedef enum logic [2:0] {
        IDLE, LOOKUP, COMPARE, MEM_WAIT, FILL, FILL_RD, RESP
    } state_t;
endpackage

// File: rtl/cache_ctrl_stat_cnt.sv
// cache_stat_cnt: saturating statistics counter that sticks at all-ones.
module cache_stat_cnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         inc,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or posedge rst)
        if (rst) cnt <= '0;
        else if (inc && !(&cnt)) cnt <= cnt + 1'b1;
endmodule

// File: rtl/cache_ctrl.sv
// cache_ctrl: sequences CPU word reads through a direct-mapped cache array, filling from memory on a miss.
module cache_ctrl
    import cache_ctrl_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int WORD_W  = 32,
    parameter int BLOCK_W = BLOCK_SIZE,
    parameter int CNT_W   = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cpu_req,
    input  logic [ADDR_W-1:0]  cpu_addr,
    output logic               cpu_ready,
    output logic               cpu_valid,
    output logic [WORD_W-1:0]  cpu_rdata,
    output logic [ADDR_W-1:0]  cache_addr,
    output logic               cache_read,
    output logic [BLOCK_W-1:0] cache_din,
    input  logic               cache_hit,
    input  logic [WORD_W-1:0]  cache_dout,
    output logic               mem_req,
    output logic [ADDR_W-1:0]  mem_addr,
    input  logic               mem_ready,
    input  logic [BLOCK_W-1:0] mem_data,
    output logic [CNT_W-1:0]   hit_cnt,
    output logic [CNT_W-1:0]   miss_cnt
);
    state_t state, next;
    logic [ADDR_W-1:0]  addr_q;
    logic [BLOCK_W-1:0] fill_buf;
    logic [WORD_W-1:0]  rdata;
    logic               hit_inc, miss_inc;

    always_ff @(posedge clk or posedge rst)
        if (rst) state <= IDLE;
        else state <= next;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            addr_q   <= '0;
            fill_buf <= '0;
            rdata    <= '0;
        end else begin
            if (state == IDLE && cpu_req) addr_q <= cpu_addr;
            if (state == MEM_WAIT && mem_ready) fill_buf <= mem_data;
            // the hit flag in FILL_RD is ignored: a completed fill is always a hit
            if ((state == COMPARE && cache_hit) || state == FILL_RD) rdata <= cache_dout;
        end

    always_comb begin
        next       = state;
        cpu_ready  = state == IDLE;
        cpu_valid  = state == RESP;
        mem_req    = state == MEM_WAIT;
        cache_read = state != FILL;
        hit_inc    = state == COMPARE && cache_hit;
        miss_inc   = state == COMPARE && !cache_hit;
        case (state)
            IDLE:     next = cpu_req ? LOOKUP : IDLE;
            LOOKUP:   next = COMPARE;
            COMPARE:  next = cache_hit ? RESP : MEM_WAIT;
            MEM_WAIT: next = mem_ready ? FILL : MEM_WAIT;
            FILL:     next = FILL_RD;
            FILL_RD:  next = RESP;
            default:  next = IDLE;
        endcase
    end

    assign cpu_rdata  = rdata;
    assign cache_addr = addr_q;
    assign cache_din  = fill_buf;
    assign mem_addr   = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};

    cache_stat_cnt #(.W(CNT_W)) u_hit (.clk(clk), .rst(rst), .inc(hit_inc), .cnt(hit_cnt));
    cache_stat_cnt #(.W(CNT_W)) u_miss (.clk(clk), .rst(rst), .inc(miss_inc), .cnt(miss_cnt));
endmodule

// File: tb/tb_cache_ctrl.sv
// tb_cache_ctrl: directed bench with behavioural cache array and delayed-ready RAM around cache_ctrl.
module tb_cache_ctrl;
    localparam int CW = 3;
    logic clk = 0, rst = 1;
    logic cpu_req = 0;
    logic [31:0] cpu_addr = '0;
    logic cpu_ready, cpu_valid, cache_read, mem_req, mem_ready, cache_hit;
    logic [31:0] cpu_rdata, cache_addr, mem_addr, cache_dout;
    logic [511:0] cache_din, mem_data;
    logic [CW-1:0] hit_cnt, miss_cnt;
    int checks = 0, errors = 0;
    logic [3:0] mem_delay = 0, mw = 0;
    logic [31:0] seen_mem_addr;

    cache_ctrl #(.CNT_W(CW)) dut (
        .clk(clk), .rst(rst), .cpu_req(cpu_req), .cpu_addr(cpu_addr),
        .cpu_ready(cpu_ready), .cpu_valid(cpu_valid), .cpu_rdata(cpu_rdata),
        .cache_addr(cache_addr), .cache_read(cache_read), .cache_din(cache_din),
        .cache_hit(cache_hit), .cache_dout(cache_dout), .mem_req(mem_req),
        .mem_addr(mem_addr), .mem_ready(mem_ready), .mem_data(mem_data),
        .hit_cnt(hit_cnt), .miss_cnt(miss_cnt)
    );

    always #5 clk = ~clk;

    // RAM: word w of a block = its word address XOR A5A5_0000
    always_comb begin
        mem_data = '0;
        for (int w = 0; w < 16; w++)
            mem_data[w*32 +: 32] = {mem_addr[31:4], w[3:0]} ^ 32'hA5A5_0000;
    end
    assign mem_ready = mem_req && mw == mem_delay;
    always @(posedge clk) mw <= (mem_req && !mem_ready) ? mw + 1'b1 : 4'd0;

    // array: no reset, registered hit/dout, writes the whole block on a fill cycle
    logic         arr_v[256];
    logic [19:0]  arr_tag[256];
    logic [511:0] arr_data[256];
    initial for (int i = 0; i < 256; i++) arr_v[i] = 0;
    initial begin cache_hit = 0; cache_dout = '0; end
    always @(posedge clk)
        if (cache_read) begin
            cache_hit  <= arr_v[cache_addr[11:4]] && arr_tag[cache_addr[11:4]] == cache_addr[31:12];
            cache_dout <= arr_data[cache_addr[11:4]][cache_addr[3:0]*32 +: 32];
        end else begin
            arr_v[cache_addr[11:4]]    <= 1;
            arr_tag[cache_addr[11:4]]  <= cache_addr[31:12];
            arr_data[cache_addr[11:4]] <= cache_din;
            cache_hit  <= 1;
            cache_dout <= cache_din[cache_addr[3:0]*32 +: 32];
        end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [31:0] a, input logic [31:0] exp_d,
                      input int exp_lat, input logic exp_miss);
        int lat = 0, fills = 0;
        logic ok = 0, saw_mem = 0;
        @(negedge clk);
        cpu_req = 1;
        cpu_addr = a;
        @(posedge clk);
        #1 cpu_req = 0;
        for (int i = 0; i < 60 && !ok; i++) begin
            @(negedge clk);
            lat++;
            if (mem_req) begin saw_mem = 1; seen_mem_addr = mem_addr; end
            if (!cache_read) fills++;
            if (cpu_valid) ok = 1;
        end
        chk({tag, "_valid"}, 32'(ok), 1);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_rdata"}, cpu_rdata, exp_d);
        chk({tag, "_memreq"}, 32'(saw_mem), 32'(exp_miss));
        chk({tag, "_fills"}, fills, exp_miss ? 1 : 0);
    endtask

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    initial begin
        int t[4];
        int acc, vcnt, busy, bad;
        logic ok;
        repeat (2) @(negedge clk);
        chk("rst_ready", 32'(cpu_ready), 1);
        chk("rst_valid", 32'(cpu_valid), 0);
        chk("rst_memreq", 32'(mem_req), 0);
        chk("rst_rdata", cpu_rdata, 0);
        chk("rst_cread", 32'(cache_read), 1);
        chk("rst_caddr", cache_addr, 0);
        chk("rst_hits", 32'(hit_cnt), 0);
        chk("rst_miss", 32'(miss_cnt), 0);
        rst = 0;

        mem_delay = 2;
        rd("cold", 32'h0000_1234, 32'hA5A5_1234, 8, 1);
        chk("cold_maddr", seen_mem_addr, 32'h0000_1230);
        chk("cold_miss", 32'(miss_cnt), 1);

        rd("rep", 32'h0000_1235, 32'hA5A5_1235, 3, 0);
        chk("rep_hits", 32'(hit_cnt), 1);

        mem_delay = 0;
        rd("cf_a", 32'h0000_1234, 32'hA5A5_1234, 3, 0);
        rd("cf_b", 32'h0010_1234, 32'hA5B5_1234, 6, 1);
        rd("cf_c", 32'h0000_1234, 32'hA5A5_1234, 6, 1);
        chk("cf_miss", 32'(miss_cnt), 3);
        chk("cf_hits", 32'(hit_cnt), 2);

        mem_delay = 5;
        @(negedge clk);
        cpu_req = 1;
        cpu_addr = 32'h0000_5678;
        @(posedge clk);
        #1 cpu_req = 0;
        ok = 0;
        for (int i = 0; i < 20 && !ok; i++) begin
            @(negedge clk);
            ok = mem_req;
        end
        chk("mr_reached", 32'(ok), 1);
        #2 rst = 1;
        #1;
        chk("mr_memreq", 32'(mem_req), 0);
        chk("mr_ready", 32'(cpu_ready), 1);
        chk("mr_hits", 32'(hit_cnt), 0);
        chk("mr_miss", 32'(miss_cnt), 0);
        @(negedge clk);
        rst = 0;
        bad = 0;
        repeat (10) begin
            @(negedge clk);
            if (cpu_valid || mem_req || !cache_read) bad++;
        end
        chk("mr_quiet", bad, 0);
        rd("mr_hit", 32'h0000_1234, 32'hA5A5_1234, 3, 0);
        chk("mr_hits2", 32'(hit_cnt), 1);

        @(negedge clk);
        cpu_req = 1;
        cpu_addr = 32'h0000_1234;
        acc = 0; vcnt = 0; busy = 0;
        for (int c = 0; c < 40 && acc < 4; c++) begin
            if (c > 0) @(negedge clk);
            if (cpu_valid) vcnt++;
            if (cpu_ready) begin t[acc] = c; acc++; end
            else busy++;
        end
        @(posedge clk);
        #1 cpu_req = 0;
        repeat (4) begin
            @(negedge clk);
            if (cpu_valid) vcnt++;
        end
        chk("bb_accepts", acc, 4);
        chk("bb_gap1", t[1] - t[0], 4);
        chk("bb_gap2", t[2] - t[1], 4);
        chk("bb_gap3", t[3] - t[2], 4);
        chk("bb_busy", busy, 9);
        chk("bb_valids", vcnt, 4);
        chk("bb_hits", 32'(hit_cnt), 5);

        rd("sat1", 32'h0000_1236, 32'hA5A5_1236, 3, 0);
        chk("sat1_hits", 32'(hit_cnt), 6);
        rd("sat2", 32'h0000_1236, 32'hA5A5_1236, 3, 0);
        chk("sat2_hits", 32'(hit_cnt), 7);
        rd("sat3", 32'h0000_1236, 32'hA5A5_1236, 3, 0);
        chk("sat3_hits", 32'(hit_cnt), 7);
        chk("sat_miss", 32'(miss_cnt), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
